tl_ul_arbiter_2to1: RTL and testbench
=====================================

Name: tl_ul_arbiter_2to1

Overview:
- TileLink UL arbiter. Shares one slave port (s) between two masters (m0, m1) on channels A and D.
- Arbitrates Channel A. Tags the forwarded source ID with the winning master index. Routes Channel D responses back by that tag.
- Tracks outstanding requests per master and throttles a master when its limit is reached.
- Sits between master-side TL agents and a single tl_interconnect / slave endpoint. Single-beat transfers only.

Parameters:
- MAX_OUTSTANDING, 4, maximum A-accepted-but-not-D-returned requests per master (1..15).
- CNT_W, 4, outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_a_opcode/param/size/source/address/mask/data  in  3/3/TL_SIZE_BITS/TL_SOURCE_BITS/TL_ADDR_BITS/TL_DATA_BYTES/TL_DATA_BYTES*8  Channel A payload, N=0,1
- mN_a_valid  in  1  master A valid, N=0,1
- mN_a_ready  out  1  master A ready, N=0,1
- mN_d_opcode/param/size/source/sink/denied/data  out  4/2/TL_SIZE_BITS/TL_SOURCE_BITS/TL_SINK_BITS/1/TL_DATA_BYTES*8  Channel D payload to master N
- mN_d_valid  out  1  D valid to master N
- mN_d_ready  in  1  D ready from master N
- s_a_opcode/param/size/address/mask/data  out  as mN_a_*  forwarded A payload
- s_a_source  out  TL_SOURCE_BITS+1  {grant_idx, mN_a_source}
- s_a_valid  out  1  forwarded A valid
- s_a_ready  in  1  slave A ready
- s_d_opcode/param/size/sink/denied/data  in  as mN_d_*  slave D payload
- s_d_source  in  TL_SOURCE_BITS+1  tagged source; MSB selects master
- s_d_valid  in  1  slave D valid
- s_d_ready  out  1  slave D ready
- err_sticky  out  1  set on a D beat routed to a master whose count is 0; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0 (m0 preferred first), lock=0, lock_idx=0, cnt0=cnt1=0, err_sticky=0.
  - All ready/valid outputs are combinationally 0 while reset is asserted.
- Eligibility: eligN = mN_a_valid && (cntN < MAX_OUTSTANDING).
- Grant selection (combinational):
  - If lock=1, grant = lock_idx.
  - Else if only one master is eligible, grant = that master.
  - Else if both are eligible, grant = rr_ptr.
  - Else no grant; s_a_valid=0.
- A forwarding:
  - s_a_valid = eligible(grant).
  - Payload is muxed from the granted master.
  - m(grant)_a_ready = s_a_ready && eligible(grant); the other master's ready = 0.
  - Zero-latency combinational path.
- Lock (TL valid-stability rule):
  - s_a_valid=1 && s_a_ready=0 sets lock=1 and lock_idx=grant at the next edge.
  - An A fire (s_a_valid && s_a_ready) clears lock.
  - A granted request is never displaced before it fires.
- Round robin: on each A fire, rr_ptr <= ~grant. No fire leaves rr_ptr unchanged.
- Counters:
  - cntN increments on mN A fire and decrements on mN D fire.
  - Simultaneous A and D fire for the same master leaves the count unchanged.
  - Saturates at 0. A decrement request at 0 sets err_sticky, and the D beat is still delivered.
- D routing (combinational, zero latency):
  - idx = s_d_source[TL_SOURCE_BITS].
  - m(idx)_d_valid = s_d_valid; the other master's d_valid = 0.
  - s_d_ready = m(idx)_d_ready.
  - mN_d_source = s_d_source[TL_SOURCE_BITS-1:0]. Other payload fields are broadcast to both masters.
- Full: cntN == MAX_OUTSTANDING holds mN_a_ready=0. If lock is already held for that master, the locked beat still completes.
- A and D are independent: an A fire and a D fire in the same cycle are both legal.
- Reset mid-transfer: in-flight state is discarded. Upstream agents are reset together with this block.

Optional Feature:
- TL_ARB_FIXED_PRIO_EN
  - Defined: m0 always wins when both masters are eligible; rr_ptr is not implemented. Lock and counters are unchanged.
  - Undefined: round robin as above.

Test Plan:
- Single master:
  - Stimulus: m1 issues Get source=3 to address 0x100, s_a_ready=1.
  - Required: same cycle s_a_valid=1, s_a_source=0b1_0011 (TL_SOURCE_BITS=4), cnt1=1.
  - Stimulus: slave returns AccessAckData source=0b1_0011.
  - Required: m1_d_valid=1, m1_d_source=3, m0_d_valid=0, cnt1=0.
- Round robin:
  - Stimulus: both masters valid continuously, s_a_ready=1, 4 cycles.
  - Required: grant order m0, m1, m0, m1. Under TL_ARB_FIXED_PRIO_EN: m0 ×4.
- Lock:
  - Stimulus: m1 granted with s_a_ready=0 for 3 cycles while m0 becomes valid.
  - Required: grant stays m1 and payload stays stable. When s_a_ready=1, m1 fires and m0 wins the next cycle.
- Throttle:
  - Stimulus: MAX_OUTSTANDING=2, m0 issues 3 requests with no D responses.
  - Required: third request sees m0_a_ready=0. One D to m0 releases it next cycle, and cnt0 returns to 2 after the third fire.
- Simultaneous events:
  - Stimulus: m0 A fire and D fire to m0 in the same cycle with cnt0=1.
  - Required: cnt0 stays 1.
  - Stimulus: D with MSB=0 while cnt0=0.
  - Required: err_sticky=1 until reset.
- Async reset:
  - Stimulus: assert rst_n=0 mid-lock with cnt1=2.
  - Required: immediately s_a_valid=0, all readies=0. After release: lock=0, counts=0, rr_ptr=0.

Source files
------------

// File: rtl/tl_ul_arbiter_2to1.sv
// tl_ul_arbiter_2to1
//   Two-master to one-slave TileLink UL arbiter for single-beat transfers.
//   Channel A is arbitrated between m0 and m1. The forwarded source ID is
//   prefixed with the winning master index. Channel D beats are routed back
//   using that prefix bit. Each master is throttled once it has
//   MAX_OUTSTANDING requests accepted on A but not yet answered on D.
//
//   Build option: define TL_ARB_FIXED_PRIO_EN to give m0 fixed priority
//   instead of round robin. Lock and counters behave the same either way.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mN_a_*  (N=0,1)     master Channel A request (valid/ready + payload)
//   mN_d_*  (N=0,1)     master Channel D response (valid/ready + payload)
//   s_a_*               forwarded Channel A to slave, source = {idx, source}
//   s_d_*               slave Channel D, s_d_source MSB selects the master
//   err_sticky          D beat seen for a master with no outstanding request
module tl_ul_arbiter_2to1 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4,
  parameter int TL_ADDR_BITS    = 32,
  parameter int TL_DATA_BYTES   = 4,
  parameter int TL_SOURCE_BITS  = 4,
  parameter int TL_SINK_BITS    = 1,
  parameter int TL_SIZE_BITS    = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // master 0, channel A
  input  logic [2:0]                  m0_a_opcode,
  input  logic [2:0]                  m0_a_param,
  input  logic [TL_SIZE_BITS-1:0]     m0_a_size,
  input  logic [TL_SOURCE_BITS-1:0]   m0_a_source,
  input  logic [TL_ADDR_BITS-1:0]     m0_a_address,
  input  logic [TL_DATA_BYTES-1:0]    m0_a_mask,
  input  logic [TL_DATA_BYTES*8-1:0]  m0_a_data,
  input  logic                        m0_a_valid,
  output logic                        m0_a_ready,
  // master 1, channel A
  input  logic [2:0]                  m1_a_opcode,
  input  logic [2:0]                  m1_a_param,
  input  logic [TL_SIZE_BITS-1:0]     m1_a_size,
  input  logic [TL_SOURCE_BITS-1:0]   m1_a_source,
  input  logic [TL_ADDR_BITS-1:0]     m1_a_address,
  input  logic [TL_DATA_BYTES-1:0]    m1_a_mask,
  input  logic [TL_DATA_BYTES*8-1:0]  m1_a_data,
  input  logic                        m1_a_valid,
  output logic                        m1_a_ready,
  // master 0, channel D
  output logic [3:0]                  m0_d_opcode,
  output logic [1:0]                  m0_d_param,
  output logic [TL_SIZE_BITS-1:0]     m0_d_size,
  output logic [TL_SOURCE_BITS-1:0]   m0_d_source,
  output logic [TL_SINK_BITS-1:0]     m0_d_sink,
  output logic                        m0_d_denied,
  output logic [TL_DATA_BYTES*8-1:0]  m0_d_data,
  output logic                        m0_d_valid,
  input  logic                        m0_d_ready,
  // master 1, channel D
  output logic [3:0]                  m1_d_opcode,
  output logic [1:0]                  m1_d_param,
  output logic [TL_SIZE_BITS-1:0]     m1_d_size,
  output logic [TL_SOURCE_BITS-1:0]   m1_d_source,
  output logic [TL_SINK_BITS-1:0]     m1_d_sink,
  output logic                        m1_d_denied,
  output logic [TL_DATA_BYTES*8-1:0]  m1_d_data,
  output logic                        m1_d_valid,
  input  logic                        m1_d_ready,
  // slave, channel A
  output logic [2:0]                  s_a_opcode,
  output logic [2:0]                  s_a_param,
  output logic [TL_SIZE_BITS-1:0]     s_a_size,
  output logic [TL_SOURCE_BITS:0]     s_a_source,
  output logic [TL_ADDR_BITS-1:0]     s_a_address,
  output logic [TL_DATA_BYTES-1:0]    s_a_mask,
  output logic [TL_DATA_BYTES*8-1:0]  s_a_data,
  output logic                        s_a_valid,
  input  logic                        s_a_ready,
  // slave, channel D
  input  logic [3:0]                  s_d_opcode,
  input  logic [1:0]                  s_d_param,
  input  logic [TL_SIZE_BITS-1:0]     s_d_size,
  input  logic [TL_SOURCE_BITS:0]     s_d_source,
  input  logic [TL_SINK_BITS-1:0]     s_d_sink,
  input  logic                        s_d_denied,
  input  logic [TL_DATA_BYTES*8-1:0]  s_d_data,
  input  logic                        s_d_valid,
  output logic                        s_d_ready,
  output logic                        err_sticky
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             lock;
  logic             lock_idx;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             pref;
  logic             elig0;
  logic             elig1;
  logic             grant;
  logic             grant_vld;
  logic             a_fire;
  logic             d_idx;
  logic             d_fire;
  logic             a_fire0;
  logic             a_fire1;
  logic             d_fire0;
  logic             d_fire1;

`ifdef TL_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic rr_ptr;
  assign pref = rr_ptr;
`endif

  assign elig0 = m0_a_valid && (cnt0 < MAX_CNT);
  assign elig1 = m1_a_valid && (cnt1 < MAX_CNT);

  // A held lock pins the grant so a stalled beat is never swapped out.
  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b0;
    if (lock) begin
      grant     = lock_idx;
      grant_vld = lock_idx ? elig1 : elig0;
    end else if (elig0 && elig1) begin
      grant     = pref;
      grant_vld = 1'b1;
    end else if (elig0) begin
      grant     = 1'b0;
      grant_vld = 1'b1;
    end else if (elig1) begin
      grant     = 1'b1;
      grant_vld = 1'b1;
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  assign s_a_valid  = rst_n && grant_vld;
  assign m0_a_ready = rst_n && grant_vld && !grant && s_a_ready;
  assign m1_a_ready = rst_n && grant_vld &&  grant && s_a_ready;
  assign a_fire     = s_a_valid && s_a_ready;
  assign a_fire0    = a_fire && !grant;
  assign a_fire1    = a_fire &&  grant;

  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = {grant, (grant ? m1_a_source : m0_a_source)};
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;

  assign d_idx      = s_d_source[TL_SOURCE_BITS];
  assign m0_d_valid = rst_n && s_d_valid && !d_idx;
  assign m1_d_valid = rst_n && s_d_valid &&  d_idx;
  assign s_d_ready  = rst_n && (d_idx ? m1_d_ready : m0_d_ready);
  assign d_fire     = s_d_valid && s_d_ready;
  assign d_fire0    = d_fire && !d_idx;
  assign d_fire1    = d_fire &&  d_idx;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_param  = s_d_param;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[TL_SOURCE_BITS-1:0];
  assign m0_d_sink   = s_d_sink;
  assign m0_d_denied = s_d_denied;
  assign m0_d_data   = s_d_data;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_param  = s_d_param;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[TL_SOURCE_BITS-1:0];
  assign m1_d_sink   = s_d_sink;
  assign m1_d_denied = s_d_denied;
  assign m1_d_data   = s_d_data;

  // Lock is taken on a stalled offer and released by the fire that ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_idx <= 1'b0;
    end else if (a_fire) begin
      lock <= 1'b0;
    end else if (s_a_valid && !s_a_ready) begin
      lock     <= 1'b1;
      lock_idx <= grant;
    end
  end

`ifndef TL_ARB_FIXED_PRIO_EN
  // After a fire the other master is preferred on the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (a_fire) begin
      rr_ptr <= ~grant;
    end
  end
`endif

  // Outstanding counters; an A and D fire for the same master cancel out.
  // A D beat for a master with nothing outstanding is flagged, not dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0       <= '0;
      cnt1       <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (a_fire0 && !d_fire0) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end else if (d_fire0 && !a_fire0 && (cnt0 != '0)) begin
        cnt0 <= cnt0 - CNT_W'(1);
      end
      if (a_fire1 && !d_fire1) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end else if (d_fire1 && !a_fire1 && (cnt1 != '0)) begin
        cnt1 <= cnt1 - CNT_W'(1);
      end
      if ((d_fire0 && (cnt0 == '0)) || (d_fire1 && (cnt1 == '0))) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// tb_tl_ul_arbiter_2to1
//   Self-checking bench for tl_ul_arbiter_2to1 (built with MAX_OUTSTANDING=2).
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a transaction-level model: per-master outstanding totals, the master
//   whose offer is stalled, and which master was served last.
module tb_tl_ul_arbiter_2to1;

  localparam int MAX = 2;
  localparam int SB  = 4;
  localparam int AB  = 32;
  localparam int DB  = 4;
  localparam int KB  = 1;
  localparam int ZB  = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]      m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [ZB-1:0]   m0_a_size, m1_a_size;
  logic [SB-1:0]   m0_a_source, m1_a_source;
  logic [AB-1:0]   m0_a_address, m1_a_address;
  logic [DB-1:0]   m0_a_mask, m1_a_mask;
  logic [DB*8-1:0] m0_a_data, m1_a_data;
  logic            m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;

  logic [3:0]      m0_d_opcode, m1_d_opcode;
  logic [1:0]      m0_d_param, m1_d_param;
  logic [ZB-1:0]   m0_d_size, m1_d_size;
  logic [SB-1:0]   m0_d_source, m1_d_source;
  logic [KB-1:0]   m0_d_sink, m1_d_sink;
  logic            m0_d_denied, m1_d_denied;
  logic [DB*8-1:0] m0_d_data, m1_d_data;
  logic            m0_d_valid, m1_d_valid, m0_d_ready, m1_d_ready;

  logic [2:0]      s_a_opcode, s_a_param;
  logic [ZB-1:0]   s_a_size;
  logic [SB:0]     s_a_source;
  logic [AB-1:0]   s_a_address;
  logic [DB-1:0]   s_a_mask;
  logic [DB*8-1:0] s_a_data;
  logic            s_a_valid, s_a_ready;

  logic [3:0]      s_d_opcode;
  logic [1:0]      s_d_param;
  logic [ZB-1:0]   s_d_size;
  logic [SB:0]     s_d_source;
  logic [KB-1:0]   s_d_sink;
  logic            s_d_denied;
  logic [DB*8-1:0] s_d_data;
  logic            s_d_valid, s_d_ready;
  logic            err_sticky;

  // Reference model state
  int cnt_m [2];
  bit held;
  bit held_idx;
  bit prefer;
  bit err_m;
  bit a_fired [2];
  bit d_fired;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tl_ul_arbiter_2to1 #(
    .MAX_OUTSTANDING(MAX), .CNT_W(4), .TL_ADDR_BITS(AB), .TL_DATA_BYTES(DB),
    .TL_SOURCE_BITS(SB), .TL_SINK_BITS(KB), .TL_SIZE_BITS(ZB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
    .m0_a_data(m0_a_data), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
    .m1_a_data(m1_a_data), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied),
    .m0_d_data(m0_d_data), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied),
    .m1_d_data(m1_d_data), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_sink(s_d_sink), .s_d_denied(s_d_denied),
    .s_d_data(s_d_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .err_sticky(err_sticky)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic modelReset();
    cnt_m[0] = 0; cnt_m[1] = 0;
    held = 1'b0; held_idx = 1'b0; prefer = 1'b0; err_m = 1'b0;
    a_fired[0] = 1'b0; a_fired[1] = 1'b0; d_fired = 1'b0;
  endtask

  task automatic idleInputs();
    m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_a_ready = 1'b0;
    s_d_valid = 1'b0; s_d_source = '0; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
  endtask

  task automatic randReq(input int n);
    if (n == 0) begin
      m0_a_opcode = 3'($urandom_range(0, 4)); m0_a_param = '0; m0_a_size = 3'd2;
      m0_a_source = 4'($urandom); m0_a_address = $urandom; m0_a_mask = 4'hf; m0_a_data = $urandom;
    end else begin
      m1_a_opcode = 3'($urandom_range(0, 4)); m1_a_param = '0; m1_a_size = 3'd2;
      m1_a_source = 4'($urandom); m1_a_address = $urandom; m1_a_mask = 4'hf; m1_a_data = $urandom;
    end
  endtask

  task automatic randResp(input bit idx);
    s_d_opcode = 4'($urandom_range(0, 1)); s_d_param = '0; s_d_size = 3'd2;
    s_d_source = {idx, 4'($urandom)}; s_d_sink = '0; s_d_denied = 1'b0; s_d_data = $urandom;
  endtask

  // Checks the current cycle against the model, then advances one clock.
  // Called right after a falling edge with the inputs already driven.
  task automatic applyStimulus();
    bit e0, e1, any, g, idx, dr, afire, dfire;
    #1;
    e0 = m0_a_valid && (cnt_m[0] < MAX);
    e1 = m1_a_valid && (cnt_m[1] < MAX);
    any = 1'b0; g = 1'b0;
    if (held) begin
      g = held_idx; any = held_idx ? e1 : e0;
    end else if (e0 && e1) begin
`ifdef TL_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = prefer;
`endif
      any = 1'b1;
    end else if (e0 || e1) begin
      g = e1; any = 1'b1;
    end
    idx = s_d_source[SB];
    dr = idx ? m1_d_ready : m0_d_ready;

    checkOutput("s_a_valid", s_a_valid, any);
    if (any) begin
      checkOutput("s_a_source", s_a_source, g ? {1'b1, m1_a_source} : {1'b0, m0_a_source});
      checkOutput("s_a_address", s_a_address, g ? m1_a_address : m0_a_address);
      checkOutput("s_a_data", s_a_data, g ? m1_a_data : m0_a_data);
    end
    checkOutput("m0_a_ready", m0_a_ready, any && !g && s_a_ready);
    checkOutput("m1_a_ready", m1_a_ready, any && g && s_a_ready);
    checkOutput("m0_d_valid", m0_d_valid, s_d_valid && !idx);
    checkOutput("m1_d_valid", m1_d_valid, s_d_valid && idx);
    checkOutput("s_d_ready", s_d_ready, dr);
    if (s_d_valid) begin
      checkOutput("m0_d_source", m0_d_source, s_d_source[SB-1:0]);
      checkOutput("m1_d_data", m1_d_data, s_d_data);
    end
    checkOutput("err_sticky", err_sticky, err_m);

    afire = any && s_a_ready;
    dfire = s_d_valid && dr;
    a_fired[0] = afire && !g;
    a_fired[1] = afire && g;
    d_fired = dfire;
    @(posedge clk);
    if (dfire && cnt_m[idx] == 0) err_m = 1'b1;
    for (int n = 0; n < 2; n++) begin
      if (a_fired[n] && !(dfire && idx == n)) cnt_m[n]++;
      else if (dfire && idx == n && !a_fired[n] && cnt_m[n] > 0) cnt_m[n]--;
    end
    if (afire) begin
      held = 1'b0; prefer = !g;
    end else if (any) begin
      held = 1'b1; held_idx = g;
    end
    @(negedge clk);
  endtask

  // Answers every outstanding request so a scenario starts from empty.
  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (cnt_m[0] == 0 && cnt_m[1] == 0) break;
      randResp(cnt_m[0] == 0);
      s_d_valid = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
      applyStimulus();
      s_d_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    randReq(0); randReq(1); randResp(1'b0); s_d_source = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    applyStimulus();

    // single master: m1 Get source=3 @0x100, then its AccessAckData
    m1_a_valid = 1'b1; m1_a_opcode = 3'd4; m1_a_source = 4'd3; m1_a_address = 32'h100;
    s_a_ready = 1'b1;
    applyStimulus();
    m1_a_valid = 1'b0;
    randResp(1'b1); s_d_source = 5'b1_0011; s_d_opcode = 4'd1; s_d_valid = 1'b1;
    applyStimulus();
    s_d_valid = 1'b0;

    // round robin with both masters continuously valid
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (a_fired[0]) randReq(0);
      if (a_fired[1]) randReq(1);
    end
    idleInputs(); drain();

    // lock: m1 stalled for 3 cycles while m0 arrives
    randReq(1); m1_a_valid = 1'b1;
    applyStimulus();
    randReq(0); m0_a_valid = 1'b1;
    applyStimulus();
    applyStimulus();
    s_a_ready = 1'b1;
    applyStimulus();
    randReq(1);
    applyStimulus();
    idleInputs(); drain();

    // throttle: third request blocked until a D to m0 frees a slot
    randReq(0); m0_a_valid = 1'b1; s_a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      if (a_fired[0]) randReq(0);
    end
    randResp(1'b0); s_d_valid = 1'b1;
    applyStimulus();
    s_d_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    idleInputs(); drain();

    // simultaneous A and D fire for m0 with one outstanding
    randReq(0); m0_a_valid = 1'b1; s_a_ready = 1'b1;
    applyStimulus();
    randReq(0); randResp(1'b0); s_d_valid = 1'b1;
    applyStimulus();
    s_d_valid = 1'b0; randReq(0);
    applyStimulus();
    applyStimulus();
    idleInputs(); drain();

    // randomized traffic honouring valid stability on both channels
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(m0_a_valid && !a_fired[0])) begin
        m0_a_valid = 1'($urandom_range(0, 1)); randReq(0);
      end
      if (!(m1_a_valid && !a_fired[1])) begin
        m1_a_valid = 1'($urandom_range(0, 1)); randReq(1);
      end
      s_a_ready = ($urandom_range(0, 3) != 0);
      if (!(s_d_valid && !d_fired)) begin
        bit pick;
        pick = 1'($urandom_range(0, 1));
        if (cnt_m[pick] == 0) pick = !pick;
        randResp(pick);
        s_d_valid = (cnt_m[pick] > 0) && ($urandom_range(0, 1) == 1);
      end
      m0_d_ready = 1'($urandom_range(0, 1));
      m1_d_ready = 1'($urandom_range(0, 1));
      applyStimulus();
    end
    for (int i = 0; i < 8; i++) begin
      if (!((m0_a_valid && !a_fired[0]) || (m1_a_valid && !a_fired[1]) || (s_d_valid && !d_fired))) break;
      if (!(m0_a_valid && !a_fired[0])) m0_a_valid = 1'b0;
      if (!(m1_a_valid && !a_fired[1])) m1_a_valid = 1'b0;
      if (!(s_d_valid && !d_fired)) s_d_valid = 1'b0;
      s_a_ready = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
      applyStimulus();
    end
    idleInputs(); drain();

    // D to m0 with nothing outstanding: still delivered, error sticks
    randResp(1'b0); s_d_valid = 1'b1;
    applyStimulus();
    s_d_valid = 1'b0;
    repeat (3) applyStimulus();

    // asynchronous reset while m0 is locked and m1 has two outstanding
    randReq(1); m1_a_valid = 1'b1; s_a_ready = 1'b1;
    applyStimulus();
    randReq(1);
    applyStimulus();
    m1_a_valid = 1'b0; s_a_ready = 1'b0; randReq(0); m0_a_valid = 1'b1;
    applyStimulus();
    randResp(1'b0); s_d_valid = 1'b1; m1_a_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_s_a_valid", s_a_valid, 1'b0);
    checkOutput("rst_m0_a_ready", m0_a_ready, 1'b0);
    checkOutput("rst_m1_a_ready", m1_a_ready, 1'b0);
    checkOutput("rst_m0_d_valid", m0_d_valid, 1'b0);
    checkOutput("rst_s_d_ready", s_d_ready, 1'b0);
    checkOutput("rst_err_sticky", err_sticky, 1'b0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleInputs();
    applyStimulus();
    // counts cleared: m1 gets two accepted; then a tie goes to m0 first
    randReq(1); m1_a_valid = 1'b1; s_a_ready = 1'b1;
    applyStimulus();
    randReq(1);
    applyStimulus();
    drain();
    randReq(0); randReq(1); m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
    applyStimulus();
    idleInputs();
    applyStimulus();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
